halt_dump_monitor: RTL and testbench



---
 rtl/monitor_pkg.sv | 40 ++++
 rtl/halt_dump_monitor_if.sv | 15 +
 rtl/halt_dump_monitor_pc_stall_counter.sv | 41 ++++
 rtl/halt_dump_monitor.sv | 152 +++++++++++++++
 tb/tb_halt_dump_monitor.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/monitor_pkg.sv
// Shared types for the end-of-run halt/dump monitor: beat kinds, termination
// causes, FSM states and the cause-priority helper.
package monitor_pkg;

    typedef enum logic [1:0] {
        KIND_REG = 2'd0,
        KIND_PC  = 2'd1,
        KIND_MEM = 2'd2
    } dump_kind_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_HALT_PC = 2'd1,
        CAUSE_STALL   = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } cause_e;

    typedef enum logic [3:0] {
        S_RUN,
        S_HOLD,
        S_REG_RD,
        S_REG_OUT,
        S_PC_OUT,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_MEM_OUT,
        S_DONE
    } mon_state_e;

    localparam int IDX_W = 16;

    // A normal halt outranks a self-loop, which outranks the watchdog.
    function automatic cause_e pick_cause(input logic halt, input logic stall, input logic tmo);
        if (halt)  return CAUSE_HALT_PC;
        if (stall) return CAUSE_STALL;
        if (tmo)   return CAUSE_TIMEOUT;
        return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/halt_dump_monitor_if.sv
// Dump stream toward the UART/bench sink: one beat per valid&&ready.
interface halt_dump_monitor_if
    import monitor_pkg::*;
#(
    parameter int XLEN = 32
);
    logic             valid;
    logic             ready;
    dump_kind_e       kind;
    logic [IDX_W-1:0] index;
    logic [XLEN-1:0]  data;

    modport master (output valid, kind, index, data, input ready);
    modport slave  (input valid, kind, index, data, output ready);
endinterface

// File: rtl/halt_dump_monitor_pc_stall_counter.sv
// Previous-PC register plus a saturating count of consecutive matching samples;
// flags a self-loop on the STALL_LIMIT-th identical sample.
module pc_stall_counter #(
    parameter int PC_W        = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_stalled
);
    localparam int              CNT_W   = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) + 1 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PC_W-1:0]  prev_pc;
    logic [CNT_W-1:0] match_cnt;
    logic             match;

    assign match = (i_pc == prev_pc);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_pc   <= '0;
            match_cnt <= '0;
        end else begin
            prev_pc <= i_pc;
            if (!match)
                match_cnt <= '0;
            else if (match_cnt != CNT_MAX)
                match_cnt <= match_cnt + 1'b1;
        end
    end

    // N identical samples means N-1 matches, counting the one happening now.
    always_comb begin
        o_stalled = 1'b0;
        if (STALL_LIMIT != 0 && match)
            o_stalled = (int'(match_cnt) + 1 >= STALL_LIMIT - 1);
    end

endmodule

// File: rtl/halt_dump_monitor.sv
// End-of-run monitor: detects halt/self-loop/timeout, freezes the core, then
// streams the register file, the latched PC and a RAM window as dump beats.
module halt_dump_monitor
    import monitor_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              PC_W        = 32,
    parameter logic [PC_W-1:0] HALT_PC     = 512,
    parameter int              REG_COUNT   = 32,
    parameter logic [PC_W-1:0] MEM_BASE    = 'h1000,
    parameter int              MEM_WORDS   = 1,
    parameter int              STALL_LIMIT = 16,
    parameter int              TIMEOUT     = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [PC_W-1:0] i_pc,
    output logic            o_cpu_hold,
    output logic [4:0]      o_reg_addr,
    input  logic [XLEN-1:0] i_reg_data,
    output logic            o_mem_re,
    output logic [PC_W-1:0] o_mem_addr,
    input  logic [XLEN-1:0] i_mem_data,
    halt_dump_monitor_if.master dump,
    output logic            o_halted,
    output logic [1:0]      o_cause,
    output logic            o_timeout,
    output logic            o_done
);
    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);
    localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT - 1);

    mon_state_e       state, state_d;
    cause_e           cause_q, cause_d;
    logic [31:0]      cycle_cnt;
    logic [PC_W-1:0]  pc_q;
    logic [IDX_W-1:0] idx;
    dump_kind_e       beat_kind;
    logic [IDX_W-1:0] beat_index;
    logic [XLEN-1:0]  beat_data;
    logic             stalled, halt_hit, to_hit, beat_state, fire, frozen;
    logic [PC_W-1:0]  mem_addr_calc;

    pc_stall_counter #(
        .PC_W       (PC_W),
        .STALL_LIMIT(STALL_LIMIT)
    ) u_stall (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_pc     (i_pc),
        .o_stalled(stalled)
    );

    assign halt_hit      = (i_pc == HALT_PC);
    assign to_hit        = (TIMEOUT != 0) && (cycle_cnt == TO_LAST);
    assign cause_d       = pick_cause(halt_hit, stalled, to_hit);
    assign beat_state    = (state == S_REG_OUT) || (state == S_PC_OUT) || (state == S_MEM_OUT);
    assign fire          = beat_state && dump.ready;
    assign frozen        = (state != S_RUN);
    assign mem_addr_calc = MEM_BASE + PC_W'({idx, 2'b00});

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_RUN;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_RUN:      if (cause_d != CAUSE_NONE) state_d = S_HOLD;
            S_HOLD:     state_d = S_REG_RD;
            S_REG_RD:   state_d = S_REG_OUT;
            S_REG_OUT:  if (fire) state_d = (idx == REG_LAST) ? S_PC_OUT : S_REG_RD;
            S_PC_OUT:   if (fire) state_d = (MEM_WORDS > 0) ? S_MEM_REQ : S_DONE;
            S_MEM_REQ:  state_d = S_MEM_WAIT;
            S_MEM_WAIT: state_d = S_MEM_OUT;
            S_MEM_OUT:  if (fire) state_d = (idx == MEM_LAST) ? S_DONE : S_MEM_REQ;
            S_DONE:     state_d = S_DONE;
            default:    state_d = S_RUN;
        endcase
    end

    // Beat registers load only on entry to a beat state, so they hold under backpressure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cycle_cnt  <= '0;
            cause_q    <= CAUSE_NONE;
            pc_q       <= '0;
            idx        <= '0;
            beat_kind  <= KIND_REG;
            beat_index <= '0;
            beat_data  <= '0;
        end else begin
            unique case (state)
                S_RUN: begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                    if (cause_d != CAUSE_NONE) begin
                        cause_q <= cause_d;
                        pc_q    <= i_pc;
                    end
                end
                S_HOLD: idx <= '0;
                S_REG_RD: begin
                    beat_kind  <= KIND_REG;
                    beat_index <= idx;
                    beat_data  <= i_reg_data;
                end
                S_REG_OUT: if (fire) begin
                    if (idx == REG_LAST) begin
                        idx        <= '0;
                        beat_kind  <= KIND_PC;
                        beat_index <= '0;
                        beat_data  <= XLEN'(pc_q);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_PC_OUT: if (fire) idx <= '0;
                S_MEM_WAIT: begin
                    beat_kind  <= KIND_MEM;
                    beat_index <= idx;
                    beat_data  <= i_mem_data;
                end
                S_MEM_OUT: if (fire) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_cpu_hold = frozen;
        o_halted   = frozen;
        o_cause    = cause_q;
        o_timeout  = (cause_q == CAUSE_TIMEOUT);
        o_done     = (state == S_DONE);
        o_reg_addr = '0;
        o_mem_re   = 1'b0;
        o_mem_addr = '0;
        if (state == S_REG_RD)
            o_reg_addr = idx[4:0];
        if (state == S_MEM_REQ) begin
            o_mem_re   = 1'b1;
            o_mem_addr = mem_addr_calc;
        end
        dump.valid = beat_state;
        dump.kind  = beat_kind;
        dump.index = beat_index;
        dump.data  = beat_data;
    end

endmodule

// File: tb/tb_halt_dump_monitor.sv
// Randomized bench: a reference model picks the termination cause from PC
// history, a scoreboard queue holds the expected dump, a monitor pops per beat.
module tb_halt_dump_monitor;
  import monitor_pkg::*;

  localparam int          XLEN = 32, PC_W = 32, REG_COUNT = 32, MEM_WORDS = 2;
  localparam int          STALL_LIMIT = 16, TIMEOUT = 50;
  localparam logic [31:0] HALT_PC = 32'h200, MEM_BASE = 32'h1000;
  localparam int          BEATS = REG_COUNT + 1 + MEM_WORDS;

  typedef struct { logic [1:0] kind; logic [15:0] idx; logic [31:0] data; } beat_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] pc = '0;
  logic        cpu_hold, mem_re, halted, timeout, done;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data, mem_addr, mem_q, mem_seed;
  logic [1:0]  cause;
  logic [31:0] regs [32];

  int    checks = 0, failures = 0, beats_seen = 0;
  beat_t exp_q[$];
  beat_t held, mon_e;
  bit    pend = 1'b0;

  always #5 clk = ~clk;

  halt_dump_monitor_if #(.XLEN(XLEN)) dump_bus ();

  halt_dump_monitor #(
    .XLEN(XLEN), .PC_W(PC_W), .HALT_PC(HALT_PC), .REG_COUNT(REG_COUNT), .MEM_BASE(MEM_BASE),
    .MEM_WORDS(MEM_WORDS), .STALL_LIMIT(STALL_LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_pc(pc), .o_cpu_hold(cpu_hold), .o_reg_addr(reg_addr),
    .i_reg_data(reg_data), .o_mem_re(mem_re), .o_mem_addr(mem_addr), .i_mem_data(mem_q),
    .dump(dump_bus), .o_halted(halted), .o_cause(cause), .o_timeout(timeout), .o_done(done)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E3779B1) ^ s;
  endfunction

  // Register file reads asynchronously; RAM data is only meaningful one cycle after the strobe.
  assign reg_data = regs[reg_addr];
  always @(posedge clk) mem_q <= mem_re ? mem_val(mem_addr, mem_seed) : $urandom;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) pend = 1'b0;
    else begin
      if (pend)
        check("hold_stable", 64'({dump_bus.valid, dump_bus.kind, dump_bus.index, dump_bus.data}),
              64'({1'b1, held.kind, held.idx, held.data}));
      pend = 1'b0;
      if (dump_bus.valid) begin
        if (dump_bus.ready) begin
          check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("beat_kind", 64'(dump_bus.kind), 64'(mon_e.kind));
            check("beat_index", 64'(dump_bus.index), 64'(mon_e.idx));
            check("beat_data", 64'(dump_bus.data), 64'(mon_e.data));
          end
          beats_seen++;
        end else begin
          pend = 1'b1;
          held = '{dump_bus.kind, dump_bus.index, dump_bus.data};
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    check(name, 64'({cpu_hold, halted, cause, timeout, done, dump_bus.valid, dump_bus.kind,
                     dump_bus.index, mem_re, mem_addr, reg_addr}), 64'(0));
    check({name, "_data"}, 64'(dump_bus.data), 64'(0));
  endtask

  // mode: 0 stride-16 to halt, 1 self-loop, 2 runaway, 3 halt on timeout cycle, 4 random segments.
  // rmode: 0 ready high, 1 random ready, 2 stall REG beat 5 for 5 cycles.
  task automatic run_test(input int mode, input int rmode, input bit reset_mid);
    int k = 0, run = 0, exp_cause = 0, seg_left = 0, cyc = 0, bp_left = 5, mem_reqs = 0;
    logic [31:0] p = '0, prev = '0, seg_pc = '0;
    bit have_prev = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    mem_seed = $urandom;
    exp_q.delete();
    dump_bus.ready = (rmode == 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    beats_seen = 0;
    rst = 1'b0;
    while (exp_cause == 0) begin
      case (mode)
        0: p = 32'(16 * k);
        1: p = 32'h40;
        2: p = 32'h1000 + 32'(4 * k);
        3: p = HALT_PC - 32'(4 * (TIMEOUT - 1 - k));
        default: begin
          if (seg_left == 0) begin
            seg_pc = ($urandom_range(0, 3) == 0) ? HALT_PC : 32'h100 + 32'(4 * $urandom_range(0, 15));
            seg_left = $urandom_range(1, 20);
          end
          seg_left--;
          p = seg_pc;
        end
      endcase
      pc = p;
      run = (have_prev && p == prev) ? run + 1 : 1;
      prev = p;
      have_prev = 1'b1;
      if (p == HALT_PC) exp_cause = 1;
      else if (STALL_LIMIT != 0 && run >= STALL_LIMIT) exp_cause = 2;
      else if (TIMEOUT != 0 && k == TIMEOUT - 1) exp_cause = 3;
      @(negedge clk);
      check("run_idle", 64'({halted, cpu_hold, dump_bus.valid, done, cause}), 64'(0));
      @(posedge clk);
      #1;
      k++;
    end
    for (int r = 0; r < REG_COUNT; r++) exp_q.push_back('{2'd0, 16'(r), regs[r]});
    exp_q.push_back('{2'd1, 16'd0, p});
    for (int m = 0; m < MEM_WORDS; m++)
      exp_q.push_back('{2'd2, 16'(m), mem_val(MEM_BASE + 32'(4 * m), mem_seed)});
    while (cyc < 1000) begin
      case (rmode)
        0: dump_bus.ready = 1'b1;
        1: dump_bus.ready = ($urandom_range(0, 3) != 0);
        default:
          if (dump_bus.valid && dump_bus.kind == KIND_REG && dump_bus.index == 16'd5 && bp_left > 0) begin
            dump_bus.ready = 1'b0;
            bp_left--;
          end else dump_bus.ready = 1'b1;
      endcase
      @(negedge clk);
      if (cyc == 0)
        check("cause_latched", 64'({halted, cpu_hold, cause, timeout}),
              64'({1'b1, 1'b1, 2'(exp_cause), exp_cause == 3}));
      if (cyc < 2) check("first_beat_early", 64'(dump_bus.valid), 64'(0));
      if (cyc == 2) check("first_beat_latency", 64'(dump_bus.valid), 64'(1));
      if (mem_re) begin
        check("mem_addr", 64'(mem_addr), 64'(MEM_BASE + 32'(4 * mem_reqs)));
        mem_reqs++;
        if (reset_mid) begin
          @(posedge clk);
          #1;
          rst = 1'b1;
          exp_q.delete();
          @(posedge clk);
          @(negedge clk);
          check_all_zero("reset_mid_dump");
          return;
        end
      end
      if (done) break;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("done_reached", 64'(done), 64'(1));
    if (rmode == 0) check("done_timing", 64'(cyc), 64'(2 * REG_COUNT + 2 + 3 * MEM_WORDS));
    check("beats_total", 64'(beats_seen), 64'(BEATS));
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    @(negedge clk);
    check("done_sticky", 64'({done, dump_bus.valid, halted, cpu_hold, cause}),
          64'({1'b1, 1'b0, 1'b1, 1'b1, 2'(exp_cause)}));
  endtask

  initial begin
    dump_bus.ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    mem_seed = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    run_test(0, 0, 1'b0);
    run_test(1, 1, 1'b0);
    run_test(2, 1, 1'b0);
    run_test(3, 0, 1'b0);
    run_test(0, 2, 1'b0);
    run_test(4, 1, 1'b1);
    run_test(0, 1, 1'b0);
    for (int t = 0; t < 6; t++) run_test(4, 1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
